// File: rtl/fetch_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_line_responder_pkg
// Brief   : Shared fetch-path types, defaults and line-address helpers.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_line_responder_pkg;

  // Default backing-memory line size in bytes.
  localparam int LINE_BYTES_DEF = 32;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL_REQ  = 2'd1,
    ST_FILL_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  // Line-aligned base of a byte address (offset bits cleared).
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_w);
    return addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

  // Tag part of a byte address, right-justified.
  function automatic logic [31:0] line_tag(input logic [31:0] addr, input int off_w);
    return addr >> off_w;
  endfunction

  // 32-bit word index within the line; zero when a line holds one word.
  function automatic int unsigned word_index(input logic [31:0] addr, input int off_w);
    logic [31:0] off;
    off = addr & ((32'd1 << off_w) - 32'd1);
    return int'(off >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_line_responder_if
// Brief   : Word request/response bus plus line-fill bus of the responder.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_line_responder_if
  import fetch_line_responder_pkg::*;
#(
  parameter int LINE_W = LINE_BYTES_DEF * 8
);
  // Word side (initiator -> responder)
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;
  // Line side (responder -> backing memory)
  logic              line_req_valid;
  logic [31:0]       line_req_addr;
  logic              line_req_ready;
  logic              line_resp_valid;
  logic [LINE_W-1:0] line_resp_data;

  // Responder view.
  modport slave (
    input  mem_req_valid, mem_req_addr, line_req_ready, line_resp_valid, line_resp_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data, line_req_valid, line_req_addr
  );

  // Environment view: word initiator plus backing memory.
  modport master (
    output mem_req_valid, mem_req_addr, line_req_ready, line_resp_valid, line_resp_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, line_req_valid, line_req_addr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : fetch_line_responder
// Brief   : Single-line caching memory responder for the fetch path. Hits
//           answer the cycle after acceptance; misses fill the whole line
//           from the line-granular backing port, then answer.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_line_responder
  import fetch_line_responder_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int LINE_W     = LINE_BYTES * 8,
  parameter int OFF_W      = $clog2(LINE_BYTES)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               invalidate,
  fetch_line_responder_if.slave   bus,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int TAG_W = 32 - OFF_W;
  localparam int WORDS = LINE_BYTES / 4;

  // Select the 32-bit word addressed by 'addr' out of a full line.
  function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                            input logic [31:0]       addr);
    int unsigned idx;
    logic [31:0] w;
    idx = word_index(addr, OFF_W);
    w   = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == unsigned'(i)) w = line[i*32 +: 32];
    end
    return w;
  endfunction

  state_t            r_state;
  logic              r_line_valid;
  logic              r_stale;
  logic [TAG_W-1:0]  r_tag;
  logic [LINE_W-1:0] r_line;
  logic [31:0]       r_addr;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [31:0]       r_resp_data;
  logic              r_line_req_valid;
  logic [31:0]       r_line_req_addr;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [TAG_W-1:0]  w_req_tag;
  logic              w_accept;
  logic              w_hit;
  logic [31:0]       w_hit_word;
  logic [31:0]       w_fill_word;

  assign w_req_tag   = TAG_W'(line_tag(bus.mem_req_addr, OFF_W));
  assign w_accept    = (r_state == ST_IDLE) && bus.mem_req_valid;
  // A flush in the acceptance cycle forces a miss even on a tag match.
  assign w_hit       = r_line_valid && (r_tag == w_req_tag) && !invalidate;
  assign w_hit_word  = pick_word(r_line, bus.mem_req_addr);
  assign w_fill_word = pick_word(bus.line_resp_data, r_addr);

  // Control FSM with registered bus outputs, line buffer and tag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_line_valid     <= 1'b0;
      r_stale          <= 1'b0;
      r_tag            <= '0;
      r_line           <= '0;
      r_addr           <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_data      <= '0;
      r_line_req_valid <= 1'b0;
      r_line_req_addr  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (invalidate) r_line_valid <= 1'b0;
          if (bus.mem_req_valid) begin
            r_addr      <= bus.mem_req_addr;
            r_req_ready <= 1'b0;
            if (w_hit) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_hit_word;
            end else begin
              r_state          <= ST_FILL_REQ;
              r_line_req_valid <= 1'b1;
              r_line_req_addr  <= line_base(bus.mem_req_addr, OFF_W);
            end
          end
        end
        ST_FILL_REQ: begin
          // A flush during the fill marks the incoming line as stale.
          if (invalidate) begin
            r_stale      <= 1'b1;
            r_line_valid <= 1'b0;
          end
          if (bus.line_req_ready) begin
            r_state          <= ST_FILL_WAIT;
            r_line_req_valid <= 1'b0;
            r_line_req_addr  <= '0;
          end
        end
        ST_FILL_WAIT: begin
          if (invalidate) begin
            r_stale      <= 1'b1;
            r_line_valid <= 1'b0;
          end
          if (bus.line_resp_valid) begin
            // The demand word is still served from a stale fill, but the
            // line is not kept valid for later requests.
            r_line       <= bus.line_resp_data;
            r_tag        <= r_addr[31:OFF_W];
            r_line_valid <= !(r_stale || invalidate);
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_fill_word;
          end
        end
        ST_RESP: begin
          if (invalidate) r_line_valid <= 1'b0;
          r_state     <= ST_IDLE;
          r_stale     <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating hit/miss counters, stepped at request acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign bus.mem_req_ready  = r_req_ready;
  assign bus.mem_resp_valid = r_resp_valid;
  assign bus.mem_resp_data  = r_resp_data;
  assign bus.line_req_valid = r_line_req_valid;
  assign bus.line_req_addr  = r_line_req_addr;
  assign hit_cnt            = r_hit_cnt;
  assign miss_cnt           = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_line_responder
// Brief   : Directed self-checking bench for fetch_line_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_line_responder;
  import fetch_line_responder_pkg::*;

  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int WORDS      = LINE_BYTES / 4;

  logic        clk;
  logic        rst_n;
  logic        invalidate;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  fetch_line_responder_if #(.LINE_W(LINE_W)) bus ();

  fetch_line_responder #(.LINE_BYTES(LINE_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .invalidate (invalidate),
    .bus        (bus),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // From FILL_REQ: accept the fill, wait 'delay' cycles, deliver the line.
  task automatic fill(input string tag, input logic [31:0] base, input int delay);
    bus.line_req_ready = 1'b1;
    tick();
    bus.line_req_ready = 1'b0;
    chk({tag, "_lrv_drop"}, 32'(bus.line_req_valid), 32'd0);
    repeat (delay) tick();
    chk({tag, "_no_early_resp"}, 32'(bus.mem_resp_valid), 32'd0);
    bus.line_resp_valid = 1'b1;
    bus.line_resp_data  = mk_line(base);
    tick();
    bus.line_resp_valid = 1'b0;
    bus.line_resp_data  = '0;
  endtask

  // In RESP: check the response, then return to IDLE and drop the request.
  task automatic end_resp(input string tag, input logic [31:0] exp);
    chk({tag, "_rv"},   32'(bus.mem_resp_valid), 32'd1);
    chk({tag, "_data"}, bus.mem_resp_data, exp);
    tick();
    bus.mem_req_valid = 1'b0;
    chk({tag, "_rv_off"},   32'(bus.mem_resp_valid), 32'd0);
    chk({tag, "_data_off"}, bus.mem_resp_data, 32'd0);
    chk({tag, "_ready"},    32'(bus.mem_req_ready), 32'd1);
  endtask

  task automatic start_req(input logic [31:0] addr, input logic inv);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_addr  = addr;
    invalidate        = inv;
    tick();
    invalidate        = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    invalidate          = 1'b0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_addr    = '0;
    bus.line_req_ready  = 1'b0;
    bus.line_resp_valid = 1'b0;
    bus.line_resp_data  = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", 32'(bus.mem_req_ready),  32'd1);
    chk("rst_rv",    32'(bus.mem_resp_valid), 32'd0);
    chk("rst_data",  bus.mem_resp_data,       32'd0);
    chk("rst_lrv",   32'(bus.line_req_valid), 32'd0);
    chk("rst_lra",   bus.line_req_addr,       32'd0);
    chk("rst_hit",   hit_cnt,                 32'd0);
    chk("rst_miss",  miss_cnt,                32'd0);
    rst_n = 1'b1;
    tick();

    // Cold miss to 0x1008
    bus.line_req_ready = 1'b1;
    start_req(32'h0000_1008, 1'b0);
    chk("cold_lrv",   32'(bus.line_req_valid), 32'd1);
    chk("cold_lra",   bus.line_req_addr,       32'h0000_1000);
    chk("cold_ready", 32'(bus.mem_req_ready),  32'd0);
    chk("cold_miss",  miss_cnt,                32'd1);
    fill("cold", 32'hA000_0000, 2);
    end_resp("cold", 32'hA000_0002);

    // Sequential hit to 0x100C
    start_req(32'h0000_100C, 1'b0);
    chk("hit_lrv", 32'(bus.line_req_valid), 32'd0);
    chk("hit_cnt", hit_cnt, 32'd1);
    end_resp("hit", 32'hA000_0003);

    // Line crossing to 0x1020, then back to 0x1004 misses again
    start_req(32'h0000_1020, 1'b0);
    chk("cross_lrv", 32'(bus.line_req_valid), 32'd1);
    chk("cross_lra", bus.line_req_addr, 32'h0000_1020);
    fill("cross", 32'hB000_0000, 1);
    end_resp("cross", 32'hB000_0000);
    start_req(32'h0000_1004, 1'b0);
    chk("back_lrv",  32'(bus.line_req_valid), 32'd1);
    chk("back_lra",  bus.line_req_addr, 32'h0000_1000);
    chk("back_miss", miss_cnt, 32'd3);
    fill("back", 32'hA000_0000, 0);
    end_resp("back", 32'hA000_0001);

    // Backpressure on the fill request
    start_req(32'h0000_1048, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_lrv",   32'(bus.line_req_valid), 32'd1);
      chk("bp_lra",   bus.line_req_addr, 32'h0000_1040);
      chk("bp_ready", 32'(bus.mem_req_ready), 32'd0);
      chk("bp_rv",    32'(bus.mem_resp_valid), 32'd0);
      tick();
    end
    fill("bp", 32'hC000_0000, 0);
    end_resp("bp", 32'hC000_0002);
    chk("bp_miss", miss_cnt, 32'd4);

    // Invalidate pulsed during FILL_WAIT
    start_req(32'h0000_1064, 1'b0);
    bus.line_req_ready = 1'b1;
    tick();
    bus.line_req_ready = 1'b0;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    tick();
    bus.line_resp_valid = 1'b1;
    bus.line_resp_data  = mk_line(32'hD000_0000);
    tick();
    bus.line_resp_valid = 1'b0;
    end_resp("stale", 32'hD000_0001);
    chk("stale_miss5", miss_cnt, 32'd5);
    start_req(32'h0000_1064, 1'b0);
    chk("stale_rep_lrv",  32'(bus.line_req_valid), 32'd1);
    chk("stale_rep_miss", miss_cnt, 32'd6);
    chk("stale_rep_hit",  hit_cnt, 32'd1);
    fill("rep", 32'hE000_0000, 1);
    end_resp("rep", 32'hE000_0001);

    // Fresh line now hits
    start_req(32'h0000_1060, 1'b0);
    chk("hit2_cnt", hit_cnt, 32'd2);
    end_resp("hit2", 32'hE000_0000);

    // Invalidate together with a request in IDLE is a miss
    start_req(32'h0000_1068, 1'b1);
    chk("invreq_lrv",  32'(bus.line_req_valid), 32'd1);
    chk("invreq_miss", miss_cnt, 32'd7);
    chk("invreq_hit",  hit_cnt, 32'd2);
    fill("invreq", 32'hF000_0000, 1);
    end_resp("invreq", 32'hF000_0002);

    // Asynchronous reset during FILL_WAIT, then a stray fill
    start_req(32'h0000_2000, 1'b0);
    bus.line_req_ready = 1'b1;
    tick();
    bus.line_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lrv",   32'(bus.line_req_valid), 32'd0);
    chk("arst_ready", 32'(bus.mem_req_ready),  32'd1);
    chk("arst_rv",    32'(bus.mem_resp_valid), 32'd0);
    chk("arst_miss",  miss_cnt, 32'd0);
    chk("arst_hit",   hit_cnt,  32'd0);
    tick();
    rst_n = 1'b1;
    bus.mem_req_valid   = 1'b0;
    bus.line_resp_valid = 1'b1;
    bus.line_resp_data  = mk_line(32'h5000_0000);
    tick();
    bus.line_resp_valid = 1'b0;
    bus.line_resp_data  = '0;
    chk("stray_rv",    32'(bus.mem_resp_valid), 32'd0);
    chk("stray_data",  bus.mem_resp_data, 32'd0);
    chk("stray_ready", 32'(bus.mem_req_ready), 32'd1);
    chk("stray_lrv",   32'(bus.line_req_valid), 32'd0);
    tick();
    chk("stray_rv2", 32'(bus.mem_resp_valid), 32'd0);
    // Address 0x4 matches the reset tag, so it only misses if the line stayed invalid
    start_req(32'h0000_0004, 1'b0);
    chk("post_lrv",  32'(bus.line_req_valid), 32'd1);
    chk("post_lra",  bus.line_req_addr, 32'h0000_0000);
    chk("post_rv",   32'(bus.mem_resp_valid), 32'd0);
    chk("post_miss", miss_cnt, 32'd1);
    fill("post", 32'h6000_0000, 0);
    end_resp("post", 32'h6000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_line_responder.md
Name: fetch_line_responder

Overview:
- Memory-side responder for the fetch-path word protocol: mem_req_valid/addr in, mem_resp_valid/data out.
- Serves the prefetching stream buffer as its downstream memory.
- Holds one cached cache line. Hits answer in one cycle; misses issue a line fill to the line-granular backing memory port.
- Sequential fetch and prefetch traffic mostly hits the held line.

Parameters:
LINE_BYTES, 32, bytes per backing-memory line (power of two, >=4)
LINE_W, LINE_BYTES*8, line data width
OFF_W, $clog2(LINE_BYTES), byte-offset bits within a line

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
invalidate  in  1  flush; drops the held line
mem_req_valid  in  1  word request; held high by the initiator until the response cycle, address stable meanwhile
mem_req_addr  in  32  byte address; bits [1:0] ignored
mem_req_ready  out  1  high only in IDLE
mem_resp_valid  out  1  one-cycle response pulse
mem_resp_data  out  32  response word
line_req_valid  out  1  line fill request
line_req_addr  out  32  line-aligned address ({addr[31:OFF_W], OFF_W'0})
line_req_ready  in  1  backing port accepts the fill
line_resp_valid  in  1  fill data valid (one cycle)
line_resp_data  in  LINE_W  fill line, word 0 in bits [31:0]
hit_cnt  out  32  saturating count of hits
miss_cnt  out  32  saturating count of misses

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, line_valid=0, tag=0, line buffer=0, latched addr=0, counters=0.
  - Outputs: mem_resp_valid=0, mem_resp_data=0, line_req_valid=0, line_req_addr=0, mem_req_ready=1.
- State IDLE: mem_req_ready=1. When mem_req_valid=1:
  - Latch the address.
  - Hit = line_valid && tag==addr[31:OFF_W] && !invalidate. Hit -> RESP, hit_cnt++.
  - Otherwise -> FILL_REQ, miss_cnt++.
- State FILL_REQ: line_req_valid=1, line_req_addr = latched address, line-aligned.
  - line_req_ready=1 -> FILL_WAIT, else hold.
- State FILL_WAIT:
  - On line_resp_valid: write line buffer, tag=latched addr[31:OFF_W], then -> RESP.
  - line_valid is set unless the fill is stale (see Invalidate).
- State RESP: mem_resp_valid=1 for exactly one cycle.
  - mem_resp_data = line word at latched addr[OFF_W-1:2]. Then -> IDLE.
  - mem_req_valid is still high with the old address this cycle. That is not a new request (ready=0).
- mem_resp_data is registered in RESP only and is 0 in every other state.
- Latency:
  - Hit: request accepted in cycle N, response in N+1.
  - Miss: fill request in N+1. Response is one cycle after the line_resp_valid cycle.
  - Back-to-back requests: next acceptance no earlier than the cycle after RESP.
- Invalidate:
  - In IDLE or RESP: clears line_valid at the next edge. A response in flight completes with the held data.
  - In FILL_REQ or FILL_WAIT: sets the stale flag. The fill still completes and the demand response is still delivered, because the initiator keeps its request pending across a flush. line_valid remains 0 afterwards. Stale clears on entry to IDLE.
  - Simultaneous invalidate and request in IDLE: treated as a miss.
- line_resp_valid outside FILL_WAIT is ignored. A fill arriving after a mid-fill reset is dropped.
- line_req_ready is ignored outside FILL_REQ.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- Word select uses OFF_W-2 bits. When LINE_BYTES=4, the select is constant 0.

Decomposition:
- Shared fetch package holds:
  - the state enum (IDLE, FILL_REQ, FILL_WAIT, RESP)
  - the LINE_BYTES default
  - a line-address helper function (tag/offset split)
- No sub-module needed. The word-select mux and the saturating counter stay inline.

Test Plan:
- Cold miss: request 0x0000_1008, line_req_ready=1 immediately, fill data word i = 0xA000_0000+i arrives 3 cycles later -> line_req_addr=0x0000_1000 for one cycle. mem_resp_valid 1 cycle after fill with data 0xA000_0002. miss_cnt=1.
- Sequential hit: then request 0x0000_100C -> mem_resp_valid in the next cycle, data 0xA000_0003, no line_req_valid, hit_cnt=1.
- Line crossing: request 0x0000_1020 -> new fill to 0x0000_1020. Request 0x0000_1004 afterwards misses again.
- Backpressure: line_req_ready low 5 cycles -> line_req_valid and line_req_addr stable throughout. mem_req_ready=0. No response until after fill.
- Invalidate mid-fill: invalidate pulsed in FILL_WAIT -> response still delivered with correct word. A repeat of the same address misses (miss_cnt increments).
- Async reset mid-fill: rst_n low in FILL_WAIT, then a stray line_resp_valid after release -> all outputs at reset values, no mem_resp_valid, line_valid=0.
